// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, and shifts one byte out on device clock falls.
// Optional PS2_TX_RETRY_EN re-runs a failed transfer up to RETRY_MAX extra times before reporting error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int RETRY_MAX      = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // state     | meaning
    // IDLE      | lines released; accepts tx_start when busy has dropped
    // INHIBIT   | clock held low; start bit asserted in the last cycle
    // REQ       | clock released, start bit held, waiting for first device fall
    // DATA      | data/parity/stop driven on each device clock fall
    // ACK       | waiting for the 11th fall to sample the device ACK
    // WAIT_IDLE | waiting for both lines high before reporting done
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} state_t;

    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = $clog2(RETRY_MAX + 2);
`ifdef PS2_TX_RETRY_EN
    localparam int RETRIES = RETRY_MAX;
`else
    localparam int RETRIES = 0;
`endif

    state_t        state;
    logic [7:0]    byte_r;
    logic          par;
    logic [3:0]    bitcnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmr;
    logic [AW-1:0] attempts;

    logic clk_meta, clk_s, clk_prev;
    logic dat_meta, dat_s;
    logic fall, counting, fail;

    // Synchronisers idle high so reset does not fabricate a falling edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_s    <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_s    <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_s    <= clk_meta;
            clk_prev <= clk_s;
            dat_meta <= ps2_dat_in;
            dat_s    <= dat_meta;
        end
    end

    assign fall     = clk_prev & ~clk_s;
    assign counting = (state == REQ) || (state == DATA) || (state == ACK) || (state == WAIT_IDLE);
    // A fall in the terminal cycle reloads the timer rather than failing.
    assign fail     = (counting && (tmr == '0) && !fall) || ((state == ACK) && fall && dat_s);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            byte_r     <= '0;
            par        <= 1'b0;
            bitcnt     <= '0;
            inh_cnt    <= '0;
            tmr        <= '0;
            attempts   <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            if (fall)
                tmr <= TW'(TIMEOUT_CYCLES - 1);
            else if (tmr != '0)
                tmr <= tmr - TW'(1);

            if (fail) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                if (attempts != AW'(RETRIES)) begin
                    attempts   <= attempts + AW'(1);
                    inh_cnt    <= IW'(INHIBIT_CYCLES - 1);
                    ps2_clk_oe <= 1'b1;
                    state      <= INHIBIT;
                end else begin
                    error <= 1'b1;
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        // busy is still high in the done/error cycle, so a start there is dropped.
                        busy <= 1'b0;
                        if (tx_start && !busy) begin
                            byte_r     <= tx_byte;
                            par        <= ~^tx_byte;
                            attempts   <= '0;
                            inh_cnt    <= IW'(INHIBIT_CYCLES - 1);
                            ps2_clk_oe <= 1'b1;
                            busy       <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == IW'(1))
                            ps2_dat_oe <= 1'b1;
                        if (inh_cnt == '0) begin
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b1;
                            bitcnt     <= '0;
                            tmr        <= TW'(TIMEOUT_CYCLES - 1);
                            state      <= REQ;
                        end else begin
                            inh_cnt <= inh_cnt - IW'(1);
                        end
                    end
                    REQ, DATA: begin
                        if (fall) begin
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt < 4'd8) begin
                                ps2_dat_oe <= ~byte_r[bitcnt[2:0]];
                                state      <= DATA;
                            end else if (bitcnt == 4'd8) begin
                                ps2_dat_oe <= ~par;
                            end else begin
                                ps2_dat_oe <= 1'b0;
                                state      <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (fall)
                            state <= WAIT_IDLE;
                    end
                    WAIT_IDLE: begin
                        if (clk_s && dat_s) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device model clocks frames out of the host and a
// scoreboard of expected frames (start, D0..D7, odd parity, stop) is compared against what it samples.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int RMAX = 2;
    localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int NATT = RMAX + 1;
`else
    localparam int NATT = 1;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

    // Open-collector bus: either side may pull low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [10:0] sb_q[$];

    int done_cnt  = 0;
    int err_cnt   = 0;
    bit both_seen = 1'b0;

    always @(posedge CLOCK_50) begin
        #1;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_seen = 1'b1;
    end

    function automatic logic [10:0] frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Request a send; afterwards scramble tx_byte to show it is latched.
    task automatic send(input logic [7:0] b);
        tx_byte  = b;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
        tx_byte  = ~b;
    endtask

    task automatic inhibit_phase(output int len);
        len = 0;
        while (ps2_clk_oe && len < 200) begin
            len++;
            cyc(1);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && n < 1000) begin
            cyc(1);
            n++;
        end
        chk("req_reached", n < 1000, 1);
    endtask

    // Device: samples before each fall/after each rise, ACKs by pulling data low before the 11th fall.
    task automatic dev_xfer(input logic ack, output logic [10:0] got);
        cyc(4);
        got[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            got[k]  = ps2_dat_in;
            cyc(HALF);
        end
        if (ack) dev_dat = 1'b0;
        cyc(2);
        dev_clk = 1'b0;
        cyc(HALF);
        dev_clk = 1'b1;
        cyc(HALF);
        dev_dat = 1'b1;
    endtask

    task automatic xfer_ack(input logic [7:0] b);
        logic [10:0] got, e;
        int len, n, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        sb_q.push_back(frame(b));
        send(b);
        chk("busy_start", busy, 1);
        inhibit_phase(len);
        chk("inhibit_len", len, INH);
        chk("start_bit_oe", ps2_dat_oe, 1);
        dev_xfer(1'b1, got);
        e = sb_q.pop_front();
        chk("frame", got, e);
        n = 0;
        while (!done && n < 300) begin
            cyc(1);
            n++;
        end
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 1);
        tx_start = 1'b1;
        tx_byte  = 8'h55;
        cyc(1);
        tx_start = 1'b0;
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
        chk("done_once", done_cnt - d0, 1);
        chk("no_error", err_cnt - e0, 0);
        cyc(10);
        chk("start_at_done_ignored", ps2_clk_oe, 0);
    endtask

    initial begin
        logic [10:0] got, e;
        int len, n, d0, e0, phases;
        logic prev;

        cyc(3);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        cyc(5);

        xfer_ack(8'hED);
        xfer_ack(8'h01);

        // Device never clocks.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
`ifndef PS2_TX_RETRY_EN
        inhibit_phase(len);
        chk("silent_inhibit_len", len, INH);
        n = 0;
        while (!error && n < 1000) begin
            cyc(1);
            n++;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_clk_oe", ps2_clk_oe, 0);
        chk("timeout_dat_oe", ps2_dat_oe, 0);
        cyc(1);
        chk("timeout_busy", busy, 0);
`else
        phases = 0;
        prev   = 1'b0;
        n      = 0;
        while (err_cnt == e0 && n < 3000) begin
            if (ps2_clk_oe && !prev) phases++;
            prev     = ps2_clk_oe;
            tx_start = (n == 150);
            tx_byte  = 8'h77;
            cyc(1);
            n++;
        end
        tx_start = 1'b0;
        chk("retry_inhibit_phases", phases, NATT);
        cyc(40);
        chk("retry_clk_oe_after", ps2_clk_oe, 0);
        chk("retry_busy_after", busy, 0);
`endif
        chk("silent_error_once", err_cnt - e0, 1);
        chk("silent_no_done", done_cnt - d0, 0);

        // Device clocks the frame but never ACKs.
        d0 = done_cnt;
        e0 = err_cnt;
        sb_q.push_back(frame(8'hA5));
        send(8'hA5);
        e = sb_q.pop_front();
        for (int a = 0; a < NATT; a++) begin
            if (a == 0) begin
                inhibit_phase(len);
            end else begin
                wait_req();
            end
            dev_xfer(1'b0, got);
            chk("frame_noack", got, e);
        end
        n = 0;
        while (err_cnt == e0 && n < 500) begin
            cyc(1);
            n++;
        end
        cyc(3);
        chk("noack_error_once", err_cnt - e0, 1);
        chk("noack_no_done", done_cnt - d0, 0);
        chk("noack_busy", busy, 0);

        // Reset while the device is clocking bit 4 of 0xFF.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hFF);
        inhibit_phase(len);
        cyc(4);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            cyc(HALF);
        end
        dev_clk = 1'b0;
        cyc(10);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        cyc(1);
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_dat_oe", ps2_dat_oe, 0);
        chk("midrst_busy", busy, 0);
        reset   = 1'b0;
        dev_clk = 1'b1;
        cyc(50);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_error", err_cnt - e0, 0);

        xfer_ack(8'h01);

        chk("done_error_exclusive", both_seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
